mem_port_arbiter: RTL

//  Shares one single-port 64-bit memory between instruction fetch (IF) and data load/store (D).

---
 rtl/mem_port_arbiter_if.sv | 54 +++++
 rtl/mem_port_arbiter.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// Core-side (instruction fetch and data) request/response signals plus the shared memory port.
// The arbiter takes the slave view; the core/memory environment takes the master view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32
) ();

  // Instruction fetch requester
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [31:0]       if_rdata;

  // Data load/store requester
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [63:0]       d_wdata;
  logic [7:0]        d_wmask;
  logic              d_gnt;
  logic              d_rvalid;
  logic [63:0]       d_rdata;

  // Shared memory port
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [63:0]       mem_wdata;
  logic [7:0]        mem_wmask;
  logic [63:0]       mem_rdata;

  logic              busy;

  modport slave (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata,
    input  d_req, d_we, d_addr, d_wdata, d_wmask,
    output d_gnt, d_rvalid, d_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, mem_wmask,
    input  mem_rdata,
    output busy
  );

  modport master (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata,
    output d_req, d_we, d_addr, d_wdata, d_wmask,
    input  d_gnt, d_rvalid, d_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, mem_wmask,
    output mem_rdata,
    input  busy
  );

endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-port 64-bit memory between instruction fetch and data ports.
// Define ARB_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise D has fixed priority on ties.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              nrst,
  mem_port_arbiter_if.slave bus
);

  localparam int               CNT_W    = $clog2(MEM_LAT) + 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

  if (MEM_LAT < 1 || MEM_LAT > 4) begin : g_bad_lat
    $fatal(1, "mem_port_arbiter: MEM_LAT=%0d outside legal range 1..4", MEM_LAT);
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              own_d_reg, own_d_next;
  logic              own_we_reg, own_we_next;
  logic              own_hi_reg, own_hi_next;
  logic [31:0]       if_rdata_reg, if_rdata_next;
  logic [63:0]       d_rdata_reg, d_rdata_next;

`ifdef ARB_ROUND_ROBIN_EN
  logic              last_d_reg, last_d_next;
`endif

  logic              grant_ok;
  logic              pick_d;
  logic              if_gnt_c;
  logic              d_gnt_c;
  logic              issue;
  logic              capture;
  logic              mem_we_c;
  logic [ADDR_W-1:0] mem_addr_c;
  logic [63:0]       mem_wdata_c;
  logic [7:0]        mem_wmask_c;

  // Arbitration: RESP is idle-equivalent so a new grant can overlap the completion pulse.
  always_comb begin
    grant_ok = nrst && (state_reg == ST_IDLE || state_reg == ST_RESP);
`ifdef ARB_ROUND_ROBIN_EN
    pick_d   = bus.d_req && (!bus.if_req || !last_d_reg);
`else
    pick_d   = bus.d_req;
`endif
    d_gnt_c  = grant_ok && pick_d;
    if_gnt_c = grant_ok && bus.if_req && !pick_d;
    issue    = d_gnt_c || if_gnt_c;
  end

`ifdef ARB_ROUND_ROBIN_EN
  always_comb begin
    last_d_next = last_d_reg;
    if (d_gnt_c) begin
      last_d_next = 1'b1;
    end else if (if_gnt_c) begin
      last_d_next = 1'b0;
    end
  end
`endif

  // Memory command is only driven in the grant cycle; fetches never write.
  always_comb begin
    mem_we_c    = 1'b0;
    mem_addr_c  = '0;
    mem_wdata_c = '0;
    mem_wmask_c = 8'h00;
    if (d_gnt_c) begin
      mem_we_c    = bus.d_we;
      mem_addr_c  = bus.d_addr;
      mem_wdata_c = bus.d_wdata;
      mem_wmask_c = bus.d_we ? bus.d_wmask : 8'h00;
    end else if (if_gnt_c) begin
      mem_addr_c  = bus.if_addr;
    end
  end

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    own_d_next    = own_d_reg;
    own_we_next   = own_we_reg;
    own_hi_next   = own_hi_reg;
    if_rdata_next = if_rdata_reg;
    d_rdata_next  = d_rdata_reg;
    capture       = 1'b0;

    case (state_reg)
      ST_IDLE, ST_RESP: begin
        state_next = ST_IDLE;
        if (issue) begin
          state_next  = ST_WAIT;
          cnt_next    = CNT_LOAD;
          own_d_next  = d_gnt_c;
          own_we_next = d_gnt_c && bus.d_we;
          own_hi_next = if_gnt_c && bus.if_addr[2];
        end
      end
      ST_WAIT: begin
        if (cnt_reg == '0) begin
          capture    = 1'b1;
          state_next = ST_RESP;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    // Read data lands directly in the per-port holding registers; stores leave d_rdata alone.
    if (capture) begin
      if (!own_d_reg) begin
        if_rdata_next = own_hi_reg ? bus.mem_rdata[63:32] : bus.mem_rdata[31:0];
      end else if (!own_we_reg) begin
        d_rdata_next = bus.mem_rdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_reg    <= ST_IDLE;
      cnt_reg      <= '0;
      own_d_reg    <= 1'b0;
      own_we_reg   <= 1'b0;
      own_hi_reg   <= 1'b0;
      if_rdata_reg <= '0;
      d_rdata_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      own_d_reg    <= own_d_next;
      own_we_reg   <= own_we_next;
      own_hi_reg   <= own_hi_next;
      if_rdata_reg <= if_rdata_next;
      d_rdata_reg  <= d_rdata_next;
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  // Reset pointer says IF won last, so D takes the first tie.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      last_d_reg <= 1'b0;
    end else begin
      last_d_reg <= last_d_next;
    end
  end
`endif

  assign bus.if_gnt    = if_gnt_c;
  assign bus.d_gnt     = d_gnt_c;
  assign bus.mem_en    = issue;
  assign bus.mem_we    = mem_we_c;
  assign bus.mem_addr  = mem_addr_c;
  assign bus.mem_wdata = mem_wdata_c;
  assign bus.mem_wmask = mem_wmask_c;
  assign bus.if_rvalid = nrst && (state_reg == ST_RESP) && !own_d_reg;
  assign bus.d_rvalid  = nrst && (state_reg == ST_RESP) && own_d_reg;
  assign bus.if_rdata  = if_rdata_reg;
  assign bus.d_rdata   = d_rdata_reg;
  assign bus.busy      = nrst && (state_reg != ST_IDLE);

  a_single_gnt: assert property (@(posedge clk) !(bus.if_gnt && bus.d_gnt));
  a_en_is_grant: assert property (@(posedge clk) bus.mem_en == (bus.if_gnt || bus.d_gnt));
  a_no_gnt_in_wait: assert property (@(posedge clk) (state_reg == ST_WAIT) |-> !bus.mem_en);

endmodule
